param_alu: RTL and testbench

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu.sv | 191 +++++++++++++++++++
 tb/tb_param_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/param_alu.sv
`default_nettype none
// ============================================================================
// param_alu : WIDTH-bit registered ALU (latency 1) with an optional iterative
//             unsigned divider, enabled by macro PARAM_ALU_DIV_EN.
// Rev 1.0
// ============================================================================
module param_alu #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             OUT_VALID,
  output logic             Carry_Flag,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             DivZero_Flag
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;

  // Flag vector order: {divzero, shift, cmp, logic, arith, carry}
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic               out_valid_q, out_valid_d;
  logic [5:0]         flags_q, flags_d;

  logic [WIDTH:0]     sum_c, diff_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   res_c;
  logic [5:0]         flg_c;
  logic               accept_c;

  assign sum_c    = {1'b0, A} + {1'b0, B};
  assign diff_c   = {1'b0, A} - {1'b0, B};
  assign prod_c   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign accept_c = IN_VALID & IN_READY;

  always_comb begin : comb_result
    res_c = '0;
    flg_c = '0;
    case (ALU_FUN)
      OP_ADD:  begin res_c = sum_c[WIDTH-1:0];  flg_c = {4'b0000, 1'b1, sum_c[WIDTH]}; end
      OP_SUB:  begin res_c = diff_c[WIDTH-1:0]; flg_c = {4'b0000, 1'b1, diff_c[WIDTH]}; end
      OP_MUL:  begin
        res_c = prod_c[WIDTH-1:0];
        flg_c = {4'b0000, 1'b1, |prod_c[2*WIDTH-1:WIDTH]};
      end
      OP_DIV:  begin
`ifdef PARAM_ALU_DIV_EN
        // Only the divide-by-zero case resolves here; B!=0 goes to the iterative path.
        if (B == '0) begin
          res_c = '1;
          flg_c = 6'b100010;
        end else begin
          flg_c = 6'b000010;
        end
`else
        flg_c = 6'b000010;
`endif
      end
      OP_AND:  begin res_c = A & B;    flg_c = 6'b000100; end
      OP_OR:   begin res_c = A | B;    flg_c = 6'b000100; end
      OP_NAND: begin res_c = ~(A & B); flg_c = 6'b000100; end
      OP_NOR:  begin res_c = ~(A | B); flg_c = 6'b000100; end
      OP_XOR:  begin res_c = A ^ B;    flg_c = 6'b000100; end
      OP_XNOR: begin res_c = ~(A ^ B); flg_c = 6'b000100; end
      OP_EQ:   begin res_c = (A == B) ? WIDTH'(1) : '0; flg_c = 6'b001000; end
      OP_GT:   begin res_c = (A > B)  ? WIDTH'(2) : '0; flg_c = 6'b001000; end
      OP_LT:   begin res_c = (A < B)  ? WIDTH'(3) : '0; flg_c = 6'b001000; end
      OP_SHR:  begin res_c = A >> B[SW-1:0]; flg_c = 6'b010000; end
      OP_SHL:  begin res_c = A << B[SW-1:0]; flg_c = 6'b010000; end
      default: begin res_c = '0; flg_c = '0; end
    endcase
  end

`ifdef PARAM_ALU_DIV_EN
  typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shifted_c, trial_c;
  logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c;

  // Restoring step: the dividend sits in quo_q and shifts out MSB-first into the remainder.
  assign shifted_c = {rem_q, quo_q[WIDTH-1]};
  assign trial_c   = shifted_c - {1'b0, dvs_q};
  assign rem_nxt_c = trial_c[WIDTH] ? shifted_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
  assign quo_nxt_c = {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
  assign IN_READY  = (state_q == IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign IN_READY = 1'b1;
`endif

  always_comb begin : comb_next
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
`ifdef PARAM_ALU_DIV_EN
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (state_q == DIV) begin
      rem_d = rem_nxt_c;
      quo_d = quo_nxt_c;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SW'(WIDTH - 1)) begin
        state_d     = IDLE;
        alu_out_d   = quo_nxt_c;
        flags_d     = 6'b000010;
        out_valid_d = 1'b1;
      end
    end else if (accept_c && (ALU_FUN == OP_DIV) && (B != '0)) begin
      state_d = DIV;
      rem_d   = '0;
      quo_d   = A;
      dvs_d   = B;
      cnt_d   = '0;
    end else
`endif
    if (accept_c) begin
      alu_out_d   = res_c;
      flags_d     = flg_c;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ALU_OUT      = alu_out_q;
  assign OUT_VALID    = out_valid_q;
  assign Carry_Flag   = flags_q[0];
  assign Arith_Flag   = flags_q[1];
  assign Logic_Flag   = flags_q[2];
  assign CMP_Flag     = flags_q[3];
  assign Shift_Flag   = flags_q[4];
  assign DivZero_Flag = flags_q[5];

endmodule
`default_nettype wire

// File: tb/tb_param_alu.sv
`default_nettype none
// tb_param_alu: table-driven checks of param_alu (WIDTH=16 and WIDTH=8 instances),
// plus hand-written divide, reset-abort and back-to-back sequences.
module tb_param_alu;

  logic        CLK, RST;
  logic [15:0] A, B, ALU_OUT;
  logic [3:0]  ALU_FUN;
  logic        IN_VALID, IN_READY, OUT_VALID;
  logic        cf, af, lf, mf, sf, zf;
  logic [7:0]  A8, B8, ALU_OUT8;
  logic [3:0]  FUN8;
  logic        V8, RDY8, OV8;
  logic        cf8, af8, lf8, mf8, sf8, zf8;
  logic [5:0]  flg, flg8;

  int total = 0;
  int bad   = 0;

  assign flg  = {zf, sf, mf, lf, af, cf};
  assign flg8 = {zf8, sf8, mf8, lf8, af8, cf8};

  param_alu #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .Carry_Flag(cf), .Arith_Flag(af), .Logic_Flag(lf), .CMP_Flag(mf),
    .Shift_Flag(sf), .DivZero_Flag(zf)
  );

  param_alu #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .A(A8), .B(B8), .ALU_FUN(FUN8), .IN_VALID(V8),
    .IN_READY(RDY8), .ALU_OUT(ALU_OUT8), .OUT_VALID(OV8),
    .Carry_Flag(cf8), .Arith_Flag(af8), .Logic_Flag(lf8), .CMP_Flag(mf8),
    .Shift_Flag(sf8), .DivZero_Flag(zf8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic [5:0]  flg;   // {divzero, shift, cmp, logic, arith, carry}
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input logic [5:0] f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.flg = f;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic seen;
    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    V8 = 1'b0; A8 = '0; B8 = '0; FUN8 = '0;
    #1 RST = 1'b0;
    #2;
    chk("reset_out", ALU_OUT, 16'h0);
    chk("reset_valid", OUT_VALID, 1'b0);
    chk("reset_flags", flg, 6'h0);
    chk("reset_ready", IN_READY, 1'b1);
    repeat (2) tick();
    chk("reset_ready_held", IN_READY, 1'b1);
    RST = 1'b1;

    add_vec(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 6'b000011);
    add_vec(4'h0, 16'h1234, 16'h1111, 16'h2345, 6'b000010);
    add_vec(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 6'b000011);
    add_vec(4'h1, 16'h0005, 16'h0003, 16'h0002, 6'b000010);
    add_vec(4'h2, 16'h0100, 16'h0100, 16'h0000, 6'b000011);
    add_vec(4'h2, 16'h0012, 16'h0003, 16'h0036, 6'b000010);
    add_vec(4'h4, 16'hF0F0, 16'h3C3C, 16'h3030, 6'b000100);
    add_vec(4'h5, 16'hF0F0, 16'h3C3C, 16'hFCFC, 6'b000100);
    add_vec(4'h6, 16'hF0F0, 16'h3C3C, 16'hCFCF, 6'b000100);
    add_vec(4'h7, 16'hF0F0, 16'h3C3C, 16'h0303, 6'b000100);
    add_vec(4'h8, 16'hF0F0, 16'h3C3C, 16'hCCCC, 6'b000100);
    add_vec(4'h9, 16'hF0F0, 16'h3C3C, 16'h3333, 6'b000100);
    add_vec(4'hA, 16'h5555, 16'h5555, 16'h0001, 6'b001000);
    add_vec(4'hA, 16'h5555, 16'h5554, 16'h0000, 6'b001000);
    add_vec(4'hB, 16'h0009, 16'h0003, 16'h0002, 6'b001000);
    add_vec(4'hB, 16'h0003, 16'h0009, 16'h0000, 6'b001000);
    add_vec(4'hB, 16'h8000, 16'h7FFF, 16'h0002, 6'b001000);
    add_vec(4'hC, 16'h0001, 16'h0002, 16'h0003, 6'b001000);
    add_vec(4'hC, 16'h0002, 16'h0002, 16'h0000, 6'b001000);
    add_vec(4'hD, 16'h8000, 16'h000F, 16'h0001, 6'b010000);
    add_vec(4'hD, 16'h8000, 16'h0014, 16'h0800, 6'b010000);
    add_vec(4'hE, 16'h0001, 16'h0014, 16'h0010, 6'b010000);
    add_vec(4'hE, 16'h0001, 16'h000F, 16'h8000, 6'b010000);
    add_vec(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 6'b000000);
`ifdef PARAM_ALU_DIV_EN
    add_vec(4'h3, 16'h0064, 16'h0000, 16'hFFFF, 6'b100010);
`else
    add_vec(4'h3, 16'h0064, 16'h0000, 16'h0000, 6'b000010);
    add_vec(4'h3, 16'h0064, 16'h0007, 16'h0000, 6'b000010);
`endif

    foreach (vt[i]) begin
      A = vt[i].a; B = vt[i].b; ALU_FUN = vt[i].op; IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      chk($sformatf("vec%0d_out", i), ALU_OUT, vt[i].exp);
      chk($sformatf("vec%0d_flags", i), flg, vt[i].flg);
      chk($sformatf("vec%0d_valid", i), OUT_VALID, 1'b1);
      chk($sformatf("vec%0d_ready", i), IN_READY, 1'b1);
      tick();
      chk($sformatf("vec%0d_pulse_end", i), OUT_VALID, 1'b0);
      chk($sformatf("vec%0d_hold", i), ALU_OUT, vt[i].exp);
    end

    // Back-to-back: AND, A>B, shift-left, one result per cycle
    A = 16'h00FF; B = 16'h0F0F; ALU_FUN = 4'h4; IN_VALID = 1'b1;
    tick();
    A = 16'h0009; B = 16'h0003; ALU_FUN = 4'hB;
    chk("b2b_and_out", ALU_OUT, 16'h000F);
    chk("b2b_and_flags", flg, 6'b000100);
    chk("b2b_and_valid", OUT_VALID, 1'b1);
    tick();
    A = 16'h0001; B = 16'h0014; ALU_FUN = 4'hE;
    chk("b2b_gt_out", ALU_OUT, 16'h0002);
    chk("b2b_gt_flags", flg, 6'b001000);
    chk("b2b_gt_valid", OUT_VALID, 1'b1);
    tick();
    IN_VALID = 1'b0;
    chk("b2b_shl_out", ALU_OUT, 16'h0010);
    chk("b2b_shl_flags", flg, 6'b010000);
    chk("b2b_shl_valid", OUT_VALID, 1'b1);
    tick();
    chk("b2b_end_valid", OUT_VALID, 1'b0);

`ifdef PARAM_ALU_DIV_EN
    // Divide 100/7 with a competing request held during DIV
    A = 16'h0064; B = 16'h0007; ALU_FUN = 4'h3; IN_VALID = 1'b1;
    tick();
    A = 16'h0001; B = 16'h0001; ALU_FUN = 4'h0;
    chk("div_ready_k0", IN_READY, 1'b0);
    chk("div_valid_k0", OUT_VALID, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        chk($sformatf("div_ready_k%0d", k), IN_READY, 1'b0);
        chk($sformatf("div_valid_k%0d", k), OUT_VALID, 1'b0);
      end
    end
    IN_VALID = 1'b0;
    chk("div_out", ALU_OUT, 16'h000E);
    chk("div_flags", flg, 6'b000010);
    chk("div_valid", OUT_VALID, 1'b1);
    chk("div_ready_back", IN_READY, 1'b1);
    tick();
    chk("div_pulse_end", OUT_VALID, 1'b0);
    chk("div_ignored_req", ALU_OUT, 16'h000E);

    // Reset at DIV cycle 5 aborts the divide
    A = 16'h0064; B = 16'h0007; ALU_FUN = 4'h3; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (5) tick();
    RST = 1'b0;
    #1;
    chk("abort_out", ALU_OUT, 16'h0);
    chk("abort_flags", flg, 6'h0);
    chk("abort_valid", OUT_VALID, 1'b0);
    chk("abort_ready", IN_READY, 1'b1);
    RST = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (OUT_VALID) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 1'b0);
    chk("abort_out_held", ALU_OUT, 16'h0);
`endif

    // WIDTH=8 instance
    A8 = 8'h01; B8 = 8'h02; FUN8 = 4'hC; V8 = 1'b1;
    tick();
    A8 = 8'h01; B8 = 8'h0B; FUN8 = 4'hE;
    chk("w8_lt_out", ALU_OUT8, 8'h03);
    chk("w8_lt_flags", flg8, 6'b001000);
    chk("w8_lt_valid", OV8, 1'b1);
    tick();
    V8 = 1'b0;
    chk("w8_shl_out", ALU_OUT8, 8'h08);
    chk("w8_shl_flags", flg8, 6'b010000);
    tick();
    chk("w8_pulse_end", OV8, 1'b0);
    chk("w8_ready", RDY8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
